// File: rtl/load_address_buffer.sv
// In-order load queue between the AGU and the data-memory port; one load outstanding, result on the CDB.
// Optional feature: LOAD_BUFFER_BYPASS_EN lets a write into an empty idle buffer request memory in the same cycle.
module load_address_buffer #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 4,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     write_to_buffer,
    input  logic [XLEN-1:0]          address_in,
    input  logic [ROB_TAG_WIDTH-1:0] rob_tag_in,
    output logic                     full,
    input  logic                     flush,
    output logic                     mem_req_valid,
    output logic [XLEN-1:0]          mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_data,
    output logic                     cdb_valid,
    output logic [XLEN-1:0]          cdb_data,
    output logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag,
    input  logic                     cdb_grant
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BCAST,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    logic [XLEN-1:0]          r_addr_mem [DEPTH];
    logic [ROB_TAG_WIDTH-1:0] r_tag_mem  [DEPTH];
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [PW:0]              r_count;
    logic                     r_req_valid;
    logic [XLEN-1:0]          r_req_addr;
    logic [ROB_TAG_WIDTH-1:0] r_req_tag;
    logic                     r_cdb_valid;
    logic [XLEN-1:0]          r_cdb_data;
    logic [ROB_TAG_WIDTH-1:0] r_cdb_tag;

    logic                     w_full;
    logic                     w_bypass;
    logic                     w_bypass_take;
    logic                     w_enq;
    logic                     w_deq;
    logic [PW:0]              w_count_next;

    assign w_full = (r_count == CW'(DEPTH));

`ifdef LOAD_BUFFER_BYPASS_EN
    assign w_bypass = (r_state == S_IDLE) && (r_count == '0) && write_to_buffer && !flush;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_bypass_take = w_bypass && mem_req_ready;

    assign w_enq = write_to_buffer && !w_full && !flush && !w_bypass_take;
    assign w_deq = (r_state == S_REQ) && mem_req_ready && !flush;
    assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr_mem[r_tail] <= address_in;
            r_tag_mem[r_tail]  <= rob_tag_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_tag   <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_tag   <= '0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_req_valid <= 1'b0;
            r_cdb_valid <= 1'b0;
            case (r_state)
                S_WAIT, S_DRAIN: r_state <= mem_resp_valid ? S_IDLE : S_DRAIN;
                // a request accepted in the flush cycle still owes a response; drain it
                S_REQ:           r_state <= mem_req_ready ? S_DRAIN : S_IDLE;
                default:         r_state <= S_IDLE;
            endcase
        end else begin
            if (w_enq) r_tail <= r_tail + PW'(1);
            if (w_deq) r_head <= r_head + PW'(1);
            r_count <= w_count_next;
            case (r_state)
                S_IDLE: begin
                    if (w_bypass_take) begin
                        r_req_tag <= rob_tag_in;
                        r_state   <= S_WAIT;
                    end else if (r_count != '0) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_addr_mem[r_head];
                        r_req_tag   <= r_tag_mem[r_head];
                        r_state     <= S_REQ;
                    end else if (w_enq) begin
                        // empty queue: the entry being written becomes the head
                        r_req_valid <= 1'b1;
                        r_req_addr  <= address_in;
                        r_req_tag   <= rob_tag_in;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_cdb_valid <= 1'b1;
                        r_cdb_data  <= mem_resp_data;
                        r_cdb_tag   <= r_req_tag;
                        r_state     <= S_BCAST;
                    end
                end
                S_BCAST: begin
                    if (cdb_grant) begin
                        r_cdb_valid <= 1'b0;
                        if (r_count != '0) begin
                            r_req_valid <= 1'b1;
                            r_req_addr  <= r_addr_mem[r_head];
                            r_req_tag   <= r_tag_mem[r_head];
                            r_state     <= S_REQ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign full          = w_full;
    assign mem_req_valid = r_req_valid | w_bypass;
    assign mem_req_addr  = w_bypass ? address_in : r_req_addr;
    assign cdb_valid     = r_cdb_valid;
    assign cdb_data      = r_cdb_data;
    assign cdb_rob_tag   = r_cdb_tag;

endmodule
